// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_OP   = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/seq_mult.sv
// Sequential W x W multiplier: sign-magnitude pre/post processing around an
// unsigned shift-add core, one multiplier bit per OP cycle.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           ready,
  output logic           done_tick,
  output logic [2*W-1:0] prod
);

  localparam int NW = $clog2(W + 1);
  localparam int PW = 2 * W;

  state_t        state;
  logic [NW-1:0] n;
  logic [PW-1:0] acc;
  logic [W-1:0]  a, b;
  logic          sgn, neg;

  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    sum;
  logic [PW-1:0] acc_nxt, acc_neg;
  logic [W-1:0]  b_nxt;
  logic [NW-1:0] n_dec;

  // Datapath: the magnitude of the most-negative value fits as unsigned W bits.
  always_comb begin
    a_mag   = (sgn && a[W-1]) ? (~a + W'(1)) : a;
    b_mag   = (sgn && b[W-1]) ? (~b + W'(1)) : b;
    sum     = b[0] ? ({1'b0, acc[PW-1:W]} + {1'b0, a}) : {1'b0, acc[PW-1:W]};
    acc_nxt = {sum, acc[W-1:1]};
    b_nxt   = {acc[0], b[W-1:1]};
    acc_neg = ~acc + PW'(1);
    n_dec   = n - NW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      n         <= '0;
      acc       <= '0;
      a         <= '0;
      b         <= '0;
      sgn       <= 1'b0;
      neg       <= 1'b0;
      prod      <= '0;
      ready     <= 1'b1;
      done_tick <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a     <= mcand;
          b     <= mplier;
          sgn   <= signed_mode;
          ready <= 1'b0;
          state <= S_LOAD;
        end
        S_LOAD: begin
          a     <= a_mag;
          b     <= b_mag;
          neg   <= sgn & (a[W-1] ^ b[W-1]);
          n     <= NW'(W);
          acc   <= '0;
          state <= S_OP;
        end
        S_OP: begin
          acc <= acc_nxt;
          b   <= b_nxt;
          n   <= n_dec;
          if (n_dec == '0) state <= S_FIX;
        end
        S_FIX: begin
          prod      <= neg ? acc_neg : acc;
          done_tick <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
